// File: rtl/gray_pkg.sv
// Shared definitions for the gray-code monitor: code width, monitor states and
// the error cause encoding reported on ErrCode.
package gray_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_ERR   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_MULTI   = 2'b01,
    ERR_NONSUCC = 2'b10,
    ERR_OVF     = 2'b11
  } err_code_t;

endpackage

// File: rtl/gray2bin.sv
// Purely combinational gray-to-binary decoder: each binary bit is the XOR of
// all gray bits at or above its position.
module gray2bin
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] binary
);

  always_comb begin
    binary = '0;
    for (int i = 0; i < GRAY_W; i++) begin
      binary[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_monitor.sv
// Watches the output of an upstream gray counter, decodes it, pulses Step on
// each legal advance, counts wraps and latches the first protocol violation.
module gray_monitor
  import gray_pkg::*;
#(
  parameter int LAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [GRAY_W-1:0] Gray,
  input  logic              Ovf,
  output logic [GRAY_W-1:0] Binary,
  output logic              Step,
  output logic              Error,
  output logic [1:0]        ErrCode,
  output logic [LAP_W-1:0]  Laps,
  output logic              LapSat
);

  state_t            state     = ST_IDLE;
  logic [GRAY_W-1:0] prev_gray = '0;
  logic              prev_ovf  = 1'b0;
  logic [GRAY_W-1:0] bin_q     = '0;
  logic              step_q    = 1'b0;
  logic              err_q     = 1'b0;
  err_code_t         code_q    = ERR_NONE;
  logic [LAP_W-1:0]  laps_q    = '0;

  logic [GRAY_W-1:0] cur_bin;
  logic [GRAY_W-1:0] prev_bin;
  logic [GRAY_W-1:0] diff;
  int                flips;
  logic              is_succ;
  logic              wrap;
  logic              ovf_bad;
  err_code_t         viol;

  gray2bin u_dec_cur (
    .gray   (Gray),
    .binary (cur_bin)
  );

  gray2bin u_dec_prev (
    .gray   (prev_gray),
    .binary (prev_bin)
  );

  // Classify the incoming sample against the last accepted one; the
  // if/else chain encodes the 01 > 10 > 11 cause priority.
  always_comb begin
    diff    = Gray ^ prev_gray;
    flips   = $countones(diff);
    is_succ = (cur_bin == prev_bin + GRAY_W'(1));
    wrap    = is_succ && (prev_bin == '1);
    ovf_bad = (Ovf && !prev_ovf && !wrap) || (!Ovf && prev_ovf);
    viol    = ERR_NONE;
    if (flips >= 2) begin
      viol = ERR_MULTI;
    end else if (flips == 1 && !is_succ) begin
      viol = ERR_NONSUCC;
    end else if (ovf_bad) begin
      viol = ERR_OVF;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      prev_gray <= '0;
      prev_ovf  <= 1'b0;
      bin_q     <= '0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      laps_q    <= '0;
    end else begin
      step_q <= 1'b0;
      if (Valid) begin
        case (state)
          ST_IDLE: begin
            bin_q     <= cur_bin;
            prev_gray <= Gray;
            prev_ovf  <= Ovf;
            state     <= ST_TRACK;
          end
          ST_TRACK: begin
            if (viol != ERR_NONE) begin
              err_q  <= 1'b1;
              code_q <= viol;
              state  <= ST_ERR;
            end else if (is_succ) begin
              bin_q     <= cur_bin;
              step_q    <= 1'b1;
              prev_gray <= Gray;
              prev_ovf  <= Ovf;
              if (wrap && laps_q != '1) begin
                laps_q <= laps_q + LAP_W'(1);
              end
            end
          end
          ST_ERR: begin
            state <= ST_ERR;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign Binary  = bin_q;
  assign Step    = step_q;
  assign Error   = err_q;
  assign ErrCode = code_q;
  assign Laps    = laps_q;
  assign LapSat  = &laps_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor: directed protocol scenarios followed by
// randomized traffic, all compared against a sequence-index reference model.
module tb_gray_monitor;

  localparam int LAPW    = 2;
  localparam int LAP_MAX = (1 << LAPW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            valid = 1'b0;
  logic [2:0]      grayIn = 3'b000;
  logic            ovfIn = 1'b0;
  logic [2:0]      binaryOut;
  logic            stepOut;
  logic            errorOut;
  logic [1:0]      errCode;
  logic [LAPW-1:0] laps;
  logic            lapSat;

  int checkCount = 0;
  int failCount  = 0;
  int stepsSeen  = 0;

  logic [2:0] graySeq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                              3'b110, 3'b111, 3'b101, 3'b100};

  bit         mStarted, mErr, mStep, mPrevOvf;
  int         mCode, mBin, mLaps;
  logic [2:0] mPrevGray;

  gray_monitor #(.LAP_W(LAPW)) dut (
    .Clk     (clk),
    .Reset   (reset),
    .Valid   (valid),
    .Gray    (grayIn),
    .Ovf     (ovfIn),
    .Binary  (binaryOut),
    .Step    (stepOut),
    .Error   (errorOut),
    .ErrCode (errCode),
    .Laps    (laps),
    .LapSat  (lapSat)
  );

  always #5 clk = ~clk;

  function automatic int seqIndex(input logic [2:0] g);
    for (int i = 0; i < 8; i++) begin
      if (graySeq[i] == g) return i;
    end
    return 0;
  endfunction

  function automatic int bitsChanged(input logic [2:0] a, input logic [2:0] b);
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      if (a[i] != b[i]) n++;
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour: position in the gray sequence, wraps when moving 7 -> 0.
  task automatic modelStep(input bit rst, input bit vld, input logic [2:0] g, input bit ovf);
    int pv, cv, nd, code;
    bit succ, wrap;
    if (rst) begin
      mStarted = 0; mErr = 0; mStep = 0; mPrevOvf = 0;
      mCode = 0; mBin = 0; mLaps = 0; mPrevGray = 3'b000;
      return;
    end
    mStep = 0;
    if (!vld || mErr) return;
    if (!mStarted) begin
      mStarted = 1; mBin = seqIndex(g); mPrevGray = g; mPrevOvf = ovf;
      return;
    end
    pv   = seqIndex(mPrevGray);
    cv   = seqIndex(g);
    nd   = bitsChanged(g, mPrevGray);
    succ = (cv == (pv + 1) % 8);
    wrap = succ && (pv == 7);
    code = 0;
    if (nd >= 2) code = 1;
    else if (nd == 1 && !succ) code = 2;
    else if ((ovf && !mPrevOvf && !wrap) || (!ovf && mPrevOvf)) code = 3;
    if (code != 0) begin
      mErr = 1; mCode = code;
    end else if (succ) begin
      mBin = cv; mStep = 1; mPrevGray = g; mPrevOvf = ovf;
      if (wrap && mLaps < LAP_MAX) mLaps++;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit vld, input logic [2:0] g, input bit ovf);
    @(negedge clk);
    reset = rst; valid = vld; grayIn = g; ovfIn = ovf;
    modelStep(rst, vld, g, ovf);
    @(posedge clk);
    #1;
    if (stepOut === 1'b1) stepsSeen++;
    checkOutput("binary", 32'(binaryOut), 32'(mBin));
    checkOutput("step",   32'(stepOut),   32'(mStep));
    checkOutput("error",  32'(errorOut),  32'(mErr));
    checkOutput("errcode", 32'(errCode),  32'(mCode));
    checkOutput("laps",   32'(laps),      32'(mLaps));
    checkOutput("lapsat", 32'(lapSat),    32'(mLaps == LAP_MAX));
  endtask

  task automatic walkTo(input int count, input int startIdx);
    for (int i = 1; i <= count; i++) begin
      applyStimulus(0, 1, graySeq[(startIdx + i) % 8], 1'b0);
    end
  endtask

  initial begin
    int r;
    logic [2:0] ng;
    bit no;

    // Reset state and the full legal cycle with Ovf rising on the wrap.
    applyStimulus(1, 0, 3'b000, 0);
    stepsSeen = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, graySeq[i % 8], (i == 8));
    end
    checkOutput("s033_steps", 32'(stepsSeen), 32'd8);
    checkOutput("s033_laps", 32'(laps), 32'd1);
    checkOutput("s033_bin", 32'(binaryOut), 32'd0);

    // Two-bit jump, then samples after the violation must be ignored.
    applyStimulus(1, 0, 3'b000, 0);
    applyStimulus(0, 1, 3'b000, 0);
    applyStimulus(0, 1, 3'b001, 0);
    applyStimulus(0, 1, 3'b010, 0);
    checkOutput("s034_code", 32'(errCode), 32'd1);
    checkOutput("s034_bin", 32'(binaryOut), 32'd1);
    applyStimulus(0, 1, 3'b011, 0);
    applyStimulus(0, 1, 3'b010, 1);
    // Reset while in ERR, then an unchecked first sample.
    applyStimulus(1, 1, 3'b011, 0);
    applyStimulus(0, 1, 3'b101, 0);
    checkOutput("s038_err_bin", 32'(binaryOut), 32'd6);

    // Backward single-bit move.
    applyStimulus(1, 0, 3'b000, 0);
    applyStimulus(0, 1, 3'b000, 0);
    walkTo(2, 0);
    applyStimulus(0, 1, 3'b001, 0);
    checkOutput("s035_code", 32'(errCode), 32'd2);

    // Ovf rising away from a wrap.
    applyStimulus(1, 0, 3'b000, 0);
    applyStimulus(0, 1, 3'b000, 0);
    walkTo(3, 0);
    applyStimulus(0, 1, 3'b110, 1);
    checkOutput("s036_rise", 32'(errCode), 32'd3);

    // Ovf falling on an otherwise legal step.
    applyStimulus(1, 0, 3'b000, 0);
    applyStimulus(0, 1, 3'b000, 0);
    walkTo(7, 0);
    applyStimulus(0, 1, 3'b000, 1);
    applyStimulus(0, 1, 3'b001, 0);
    checkOutput("s036_fall", 32'(errCode), 32'd3);

    // Five wraps saturate the 2-bit lap counter; Valid gaps in between.
    applyStimulus(1, 0, 3'b000, 0);
    applyStimulus(0, 1, 3'b000, 0);
    for (int w = 0; w < 5; w++) begin
      for (int i = 1; i <= 8; i++) begin
        if (i == 4) applyStimulus(0, 0, 3'b111, 0);
        applyStimulus(0, 1, graySeq[i % 8], (w > 0) || (i == 8));
      end
    end
    checkOutput("s037_laps", 32'(laps), 32'd3);
    checkOutput("s037_sat", 32'(lapSat), 32'd1);
    checkOutput("s037_err", 32'(errorOut), 32'd0);
    // Reset in TRACK with Valid high.
    applyStimulus(1, 1, 3'b010, 1);
    applyStimulus(0, 1, 3'b111, 0);
    checkOutput("s038_trk_bin", 32'(binaryOut), 32'd5);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        applyStimulus(1, $urandom_range(0, 1), 3'($urandom), $urandom_range(0, 1));
      end else if (r < 20) begin
        applyStimulus(0, 0, 3'($urandom), $urandom_range(0, 1));
      end else if (r < 30 || !mStarted) begin
        applyStimulus(0, 1, mStarted ? mPrevGray : 3'($urandom), mPrevOvf);
      end else if (r < 95) begin
        ng = graySeq[(seqIndex(mPrevGray) + 1) % 8];
        no = mPrevOvf | ((seqIndex(mPrevGray) == 7) && ($urandom_range(0, 1) == 1));
        applyStimulus(0, 1, ng, no);
      end else begin
        applyStimulus(0, 1, 3'($urandom), $urandom_range(0, 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 SHALL have parameter LAP_W, default 8, width of the lap counter.
REQ-002 SHALL have Clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have Reset  input  1  reset, synchronous, active-high; clock Clk.
REQ-004 SHALL have Valid  input  1  sample qualifier; Gray/Ovf are consumed only when 1.
REQ-005 SHALL have Gray  input  3  gray code from the upstream gray counter Output.
REQ-006 SHALL have Ovf  input  1  upstream counter Overflow flag.
REQ-007 SHALL have Binary  output  3  registered binary decode of the last accepted Gray.
REQ-008 SHALL have Step  output  1  one-cycle pulse when a legal +1 advance is accepted.
REQ-009 SHALL have Error  output  1  sticky protocol-violation flag.
REQ-010 SHALL have ErrCode  output  2  cause of first violation: 00 none, 01 multi-bit change, 10 single-bit non-successor, 11 Ovf inconsistent.
REQ-011 SHALL have Laps  output  LAP_W  count of observed wraps (binary 7 -> 0).
REQ-012 SHALL have LapSat  output  1  high while Laps equals all-ones.

Function
REQ-013 SHALL implement states IDLE (no sample yet), TRACK, ERR.
REQ-014 SHALL hold all state and outputs, and drive Step=0, on any cycle with Valid=0.
REQ-015 SHALL, in IDLE with Valid=1, accept any Gray without checking, load Binary=decode(Gray), record Gray and Ovf as previous, go TRACK, Step=0.
REQ-016 SHALL, in TRACK with Valid=1 and Gray==previous, hold Binary, Step=0, no error (counter stalled).
REQ-017 SHALL, in TRACK with Valid=1 and decode(Gray)==decode(previous)+1 mod 8, update Binary, pulse Step=1 the next cycle.
REQ-018 SHALL treat previous binary 7 -> 0 as a wrap: increment Laps, saturating at 2^LAP_W-1, with no rollover.
REQ-019 SHALL flag code 01 when Gray differs from previous in 2 or more bits.
REQ-020 SHALL flag code 10 when Gray differs in exactly 1 bit but is not the successor (e.g. 000 -> 010, or backward 001 -> 000).
REQ-021 SHALL flag code 11 when Ovf rises 0 -> 1 on a sample that is not a wrap, or when Ovf falls 1 -> 0 at all.
REQ-022 SHALL accept an Ovf rise coinciding with the wrap sample as legal; Ovf staying 1 on later wraps is legal.
REQ-023 SHALL prioritise simultaneous causes 01 > 10 > 11.
REQ-024 SHALL, on a violation, set Error=1 and ErrCode, then enter ERR; Binary, Laps and Step are not updated on that sample.
REQ-025 SHALL remain in ERR with all outputs frozen and Step=0 until Reset.
REQ-026 SHALL produce outputs with 1-cycle latency from the sampling edge; no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, on Reset=1 at posedge, enter IDLE with Binary=000, Step=0, Error=0, ErrCode=00, Laps=0, LapSat=0, previous Gray/Ovf cleared.
REQ-028 SHALL give Reset priority over Valid in the same cycle, including mid-operation and in ERR.
REQ-029 SHALL provide identical power-up values via initialisation for simulation.

Structure
REQ-030 SHALL place the ErrCode constants, the state encoding and the gray width (3) in shared package gray_pkg.
REQ-031 SHALL instantiate combinational sub-module gray2bin (3-bit gray to binary) twice: once for the current sample and once for the previous sample.
REQ-032 SHALL fit within 120-400 lines of RTL; the monitor is connected to the gray counter with a common Clk/Reset.

Verification
REQ-033 Reset, then feed Valid=1 with the full gray sequence 000, 001, 011, 010, 110, 111, 101, 100, 000, asserting Ovf=1 on the final 000 -> 8 Step pulses, Binary ends at 000, Laps=1, Error=0.
REQ-034 In TRACK at 001, drive Gray=010 -> next cycle Error=1, ErrCode=01, Binary stays 001; further samples are ignored.
REQ-035 In TRACK at 011, drive Gray=001 (backward) -> Error=1, ErrCode=10.
REQ-036 In TRACK at 010, drive Gray=110 with Ovf=1 -> ErrCode=11; separately, Ovf 1 -> 0 with a legal step -> ErrCode=11.
REQ-037 Use LAP_W=2 and run 5 wraps -> Laps=3, LapSat=1, no error; toggle Valid=0 mid-sequence -> outputs hold and Step=0.
REQ-038 Assert Reset in ERR and in TRACK with Valid=1 -> next cycle all outputs equal the reset values; the first sample afterwards is accepted unchecked.
